// File: rtl/axi2apb_burst_bridge.sv
// AXI4 slave to APB4 master bridge. Holds one AXI transaction at a time and
// splits INCR/FIXED bursts into individual APB transfers. WRAP and reserved
// burst types are answered with SLVERR on every beat without touching APB.
module axi2apb_burst_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_n,

    // AXI write address channel
    input  logic                        aw_valid,
    output logic                        aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]                  aw_len,
    input  logic [2:0]                  aw_size,
    input  logic [1:0]                  aw_burst,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id,
    input  logic [AXI_USER_WIDTH-1:0]   aw_user,

    // AXI write data channel
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    input  logic                        w_last,
    input  logic [AXI_USER_WIDTH-1:0]   w_user,

    // AXI write response channel
    output logic                        b_valid,
    input  logic                        b_ready,
    output logic [1:0]                  b_resp,
    output logic [AXI_ID_WIDTH-1:0]     b_id,
    output logic [AXI_USER_WIDTH-1:0]   b_user,

    // AXI read address channel
    input  logic                        ar_valid,
    output logic                        ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]                  ar_len,
    input  logic [2:0]                  ar_size,
    input  logic [1:0]                  ar_burst,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id,
    input  logic [AXI_USER_WIDTH-1:0]   ar_user,

    // AXI read data channel
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic [AXI_DATA_WIDTH-1:0]   r_data,
    output logic [1:0]                  r_resp,
    output logic                        r_last,
    output logic [AXI_ID_WIDTH-1:0]     r_id,
    output logic [AXI_USER_WIDTH-1:0]   r_user,

    // APB4 master
    output logic [AXI_ADDR_WIDTH-1:0]   paddr,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [AXI_DATA_WIDTH-1:0]   pwdata,
    output logic [AXI_DATA_WIDTH/8-1:0] pstrb,
    input  logic [AXI_DATA_WIDTH-1:0]   prdata,
    input  logic                        pready,
    input  logic                        pslverr
);

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    // StWData waits for the next W beat between APB transfers of a write burst
    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAccess,
        StWResp,
        StRData,
        StWData
    } state_e;

    state_e                      state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic [2:0]                  size_q, size_d;
    logic [1:0]                  burst_q, burst_d;
    logic [AXI_ID_WIDTH-1:0]     id_q, id_d;
    logic                        write_q, write_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [AXI_DATA_WIDTH/8-1:0] strb_q, strb_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic                        err_q, err_d;
    logic                        last_rd_q, last_rd_d;

    logic                        wr_pend;
    logic                        rd_pend;
    logic                        grant_w;
    logic                        grant_r;
    logic                        bad_burst;
    logic [AXI_ADDR_WIDTH-1:0]   next_addr;

    // User sidebands and w_last carry no meaning for this bridge
    logic unused_inputs;
    assign unused_inputs = ^{aw_user, w_user, ar_user, w_last};

    assign wr_pend   = aw_valid & w_valid;
    assign rd_pend   = ar_valid;
    // On a tie the type not granted last wins; reset history says "last was read"
    assign grant_w   = rst_n & (state_q == StIdle) & wr_pend & (~rd_pend | last_rd_q);
    assign grant_r   = rst_n & (state_q == StIdle) & rd_pend & ~grant_w;
    assign bad_burst = (burst_q != BurstFixed) && (burst_q != BurstIncr);
    assign next_addr = (burst_q == BurstIncr) ?
                       addr_q + (AXI_ADDR_WIDTH'(1) << size_q) : addr_q;

    assign paddr   = addr_q;
    assign pwrite  = write_q;
    assign pwdata  = wdata_q;
    assign pstrb   = strb_q;
    assign b_resp  = (state_q == StWResp) ? {err_q, 1'b0} : RespOkay;
    assign b_id    = id_q;
    assign b_user  = '0;
    assign r_data  = rdata_q;
    assign r_resp  = rresp_q;
    assign r_last  = (state_q == StRData) && (cnt_q == 8'd0);
    assign r_id    = id_q;
    assign r_user  = '0;

    // Next-state, latched transaction context and handshake outputs
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        burst_d   = burst_q;
        id_d      = id_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        err_d     = err_q;
        last_rd_d = last_rd_q;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        ar_ready  = 1'b0;
        b_valid   = 1'b0;
        r_valid   = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_w) begin
                    aw_ready  = 1'b1;
                    w_ready   = 1'b1;
                    addr_d    = aw_addr;
                    cnt_d     = aw_len;
                    size_d    = aw_size;
                    burst_d   = aw_burst;
                    id_d      = aw_id;
                    write_d   = 1'b1;
                    wdata_d   = w_data;
                    strb_d    = w_strb;
                    err_d     = 1'b0;
                    last_rd_d = 1'b0;
                    state_d   = StSetup;
                end else if (grant_r) begin
                    ar_ready  = 1'b1;
                    addr_d    = ar_addr;
                    cnt_d     = ar_len;
                    size_d    = ar_size;
                    burst_d   = ar_burst;
                    id_d      = ar_id;
                    write_d   = 1'b0;
                    wdata_d   = '0;
                    strb_d    = '0;
                    err_d     = 1'b0;
                    last_rd_d = 1'b1;
                    state_d   = StSetup;
                end
            end

            StSetup: begin
                // Unsupported bursts skip APB entirely and fail the beat
                psel = ~bad_burst;
                if (bad_burst) begin
                    if (write_q) begin
                        err_d = 1'b1;
                        if (cnt_q == 8'd0) begin
                            state_d = StWResp;
                        end else begin
                            cnt_d   = cnt_q - 8'd1;
                            state_d = StWData;
                        end
                    end else begin
                        rdata_d = '0;
                        rresp_d = RespSlverr;
                        state_d = StRData;
                    end
                end else begin
                    state_d = StAccess;
                end
            end

            StAccess: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    if (write_q) begin
                        err_d = err_q | pslverr;
                        if (cnt_q == 8'd0) begin
                            state_d = StWResp;
                        end else begin
                            cnt_d   = cnt_q - 8'd1;
                            addr_d  = next_addr;
                            state_d = StWData;
                        end
                    end else begin
                        rdata_d = prdata;
                        rresp_d = {pslverr, 1'b0};
                        state_d = StRData;
                    end
                end
            end

            StWData: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    wdata_d = w_data;
                    strb_d  = w_strb;
                    state_d = StSetup;
                end
            end

            StWResp: begin
                b_valid = 1'b1;
                if (b_ready) begin
                    state_d = StIdle;
                end
            end

            StRData: begin
                r_valid = 1'b1;
                if (r_ready) begin
                    if (cnt_q == 8'd0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = next_addr;
                        state_d = StSetup;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and context registers; reset aborts any transfer in flight
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            id_q      <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
            err_q     <= 1'b0;
            last_rd_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            id_q      <= id_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            err_q     <= err_d;
            last_rd_q <= last_rd_d;
        end
    end

endmodule

// File: tb/tb_axi2apb_burst_bridge.sv
// Directed testbench for axi2apb_burst_bridge.
module tb_axi2apb_burst_bridge;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        aw_valid = 1'b0, aw_ready;
    logic [31:0] aw_addr = '0;
    logic [7:0]  aw_len = '0;
    logic [2:0]  aw_size = 3'd2;
    logic [1:0]  aw_burst = 2'b01;
    logic [3:0]  aw_id = '0;
    logic [0:0]  aw_user = '0;
    logic        w_valid = 1'b0, w_ready;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        w_last = 1'b0;
    logic [0:0]  w_user = '0;
    logic        b_valid, b_ready = 1'b0;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic [0:0]  b_user;
    logic        ar_valid = 1'b0, ar_ready;
    logic [31:0] ar_addr = '0;
    logic [7:0]  ar_len = '0;
    logic [2:0]  ar_size = 3'd2;
    logic [1:0]  ar_burst = 2'b01;
    logic [3:0]  ar_id = '0;
    logic [0:0]  ar_user = '0;
    logic        r_valid, r_ready = 1'b0;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [3:0]  r_id;
    logic [0:0]  r_user;
    logic [31:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0, pslverr = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    axi2apb_burst_bridge #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH  (4),
        .AXI_USER_WIDTH(1)
    ) dut (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .aw_size (aw_size),  .aw_burst(aw_burst), .aw_id(aw_id),     .aw_user(aw_user),
        .w_valid (w_valid),  .w_ready(w_ready),   .w_data(w_data),   .w_strb(w_strb),
        .w_last  (w_last),   .w_user(w_user),
        .b_valid (b_valid),  .b_ready(b_ready),   .b_resp(b_resp),   .b_id(b_id),
        .b_user  (b_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size (ar_size),  .ar_burst(ar_burst), .ar_id(ar_id),     .ar_user(ar_user),
        .r_valid (r_valid),  .r_ready(r_ready),   .r_data(r_data),   .r_resp(r_resp),
        .r_last  (r_last),   .r_id(r_id),         .r_user(r_user),
        .paddr   (paddr),    .psel(psel),         .penable(penable), .pwrite(pwrite),
        .pwdata  (pwdata),   .pstrb(pstrb),       .prdata(prdata),   .pready(pready),
        .pslverr (pslverr)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        aw_valid = 0; w_valid = 0; ar_valid = 0; b_ready = 0; r_ready = 0;
        pready = 0; pslverr = 0; prdata = '0; w_last = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        // Requests pending during reset must not be acknowledged
        aw_valid = 1; w_valid = 1; ar_valid = 1;
        #12;
        n_cmp++; if ({aw_ready, w_ready, ar_ready} !== 3'b000) begin n_fail++;
            $display("FAIL rst_readies: got %b want 000", {aw_ready, w_ready, ar_ready}); end
        n_cmp++; if ({psel, penable, pwrite, b_valid, r_valid} !== 5'b0) begin n_fail++;
            $display("FAIL rst_ctrl: got %b want 00000", {psel, penable, pwrite, b_valid, r_valid}); end
        n_cmp++; if ({paddr, pwdata, pstrb} !== 68'h0) begin n_fail++;
            $display("FAIL rst_apb_data: got %h want 0", {paddr, pwdata, pstrb}); end
        n_cmp++; if ({r_data, b_resp, r_resp} !== 36'h0) begin n_fail++;
            $display("FAIL rst_resp: got %h want 0", {r_data, b_resp, r_resp}); end
        clear_inputs();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_single_write();
        aw_addr = 32'h1A10_0004; aw_len = 0; aw_size = 2; aw_burst = 2'b01; aw_id = 4'h5;
        w_data = 32'hDEAD_BEEF; w_strb = 4'hF; w_last = 1;
        aw_valid = 1; w_valid = 1;
        #1;
        n_cmp++; if ({aw_ready, w_ready, ar_ready} !== 3'b110) begin n_fail++;
            $display("FAIL sw_grant: got %b want 110", {aw_ready, w_ready, ar_ready}); end
        tick();
        aw_valid = 0; w_valid = 0;
        #1;
        n_cmp++; if ({psel, penable, pwrite} !== 3'b101) begin n_fail++;
            $display("FAIL sw_setup_ctrl: got %b want 101", {psel, penable, pwrite}); end
        n_cmp++; if ({paddr, pwdata, pstrb} !== {32'h1A10_0004, 32'hDEAD_BEEF, 4'hF}) begin
            n_fail++; $display("FAIL sw_setup_data: got %h %h %h want 1a100004 deadbeef f",
                               paddr, pwdata, pstrb); end
        n_cmp++; if ({aw_ready, w_ready} !== 2'b00) begin n_fail++;
            $display("FAIL sw_setup_readies: got %b want 00", {aw_ready, w_ready}); end
        pready = 1;
        tick();
        #1;
        n_cmp++; if ({psel, penable, paddr, pwdata} !== {2'b11, 32'h1A10_0004, 32'hDEAD_BEEF})
        begin n_fail++; $display("FAIL sw_access: got %b%b %h %h want 11 1a100004 deadbeef",
                                 psel, penable, paddr, pwdata); end
        tick();
        pready = 0;
        #1;
        n_cmp++; if ({b_valid, b_resp, b_id, psel} !== {1'b1, 2'b00, 4'h5, 1'b0}) begin
            n_fail++; $display("FAIL sw_bresp: got v=%b resp=%b id=%h psel=%b want 1 00 5 0",
                               b_valid, b_resp, b_id, psel); end
        b_ready = 1;
        tick();
        b_ready = 0;
        #1;
        n_cmp++; if (b_valid !== 1'b0) begin n_fail++;
            $display("FAIL sw_bdone: got b_valid=%b want 0", b_valid); end
    endtask

    task automatic test_incr_read();
        logic [31:0] vals [4];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
        ar_addr = 32'h1A10_2000; ar_len = 3; ar_size = 2; ar_burst = 2'b01; ar_id = 4'h3;
        ar_valid = 1;
        #1;
        n_cmp++; if ({ar_ready, aw_ready} !== 2'b10) begin n_fail++;
            $display("FAIL rd_grant: got %b want 10", {ar_ready, aw_ready}); end
        tick();
        ar_valid = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if ({psel, penable, pwrite, paddr} !== {3'b100, 32'h1A10_2000 + 32'(4 * i)})
            begin n_fail++; $display("FAIL rd_setup beat %0d: got %b%b%b %h want 100 %h", i,
                                     psel, penable, pwrite, paddr, 32'h1A10_2000 + 32'(4 * i)); end
            n_cmp++; if ({pwdata, pstrb} !== 36'h0) begin n_fail++;
                $display("FAIL rd_wdata_zero beat %0d: got %h %h want 0 0", i, pwdata, pstrb); end
            pready = 1; prdata = vals[i];
            tick();
            #1;
            n_cmp++; if ({penable, paddr} !== {1'b1, 32'h1A10_2000 + 32'(4 * i)}) begin n_fail++;
                $display("FAIL rd_access beat %0d: got %b %h", i, penable, paddr); end
            tick();
            pready = 0;
            #1;
            n_cmp++; if ({r_valid, r_data, r_resp, r_last, r_id} !==
                         {1'b1, vals[i], 2'b00, (i == 3), 4'h3}) begin n_fail++;
                $display("FAIL rd_rbeat %0d: got v=%b d=%h resp=%b last=%b id=%h want 1 %h 00 %b 3",
                         i, r_valid, r_data, r_resp, r_last, r_id, vals[i], (i == 3)); end
            r_ready = 1;
            tick();
            r_ready = 0;
        end
        #1;
        n_cmp++; if ({r_valid, psel} !== 2'b00) begin n_fail++;
            $display("FAIL rd_end: got %b want 00", {r_valid, psel}); end
    endtask

    task automatic test_wait_error();
        aw_addr = 32'h1A10_0100; aw_len = 1; aw_size = 2; aw_burst = 2'b01; aw_id = 4'h9;
        w_data = 32'hCAFE_0001; w_strb = 4'h3; w_last = 0;
        aw_valid = 1; w_valid = 1;
        #1;
        tick();
        aw_valid = 0; w_valid = 0;
        tick();
        #1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if ({psel, penable, pwrite, paddr, pwdata, pstrb} !==
                         {3'b111, 32'h1A10_0100, 32'hCAFE_0001, 4'h3}) begin n_fail++;
                $display("FAIL we_wait_stable cyc %0d: got %b%b%b %h %h %h", k, psel, penable,
                         pwrite, paddr, pwdata, pstrb); end
            tick();
            #1;
        end
        pready = 1; pslverr = 1;
        tick();
        pready = 0; pslverr = 0;
        #1;
        n_cmp++; if ({w_ready, aw_ready, psel} !== 3'b100) begin n_fail++;
            $display("FAIL we_wdata_wait: got %b want 100", {w_ready, aw_ready, psel}); end
        tick();
        #1;
        n_cmp++; if (w_ready !== 1'b1) begin n_fail++;
            $display("FAIL we_wready_held: got %b want 1", w_ready); end
        // Final beat deliberately carries w_last=0
        w_data = 32'hCAFE_0002; w_strb = 4'hC; w_last = 0; w_valid = 1;
        tick();
        w_valid = 0;
        #1;
        n_cmp++; if ({psel, penable, paddr, pwdata, pstrb} !==
                     {2'b10, 32'h1A10_0104, 32'hCAFE_0002, 4'hC}) begin n_fail++;
            $display("FAIL we_beat1_setup: got %b%b %h %h %h want 10 1a100104 cafe0002 c",
                     psel, penable, paddr, pwdata, pstrb); end
        pready = 1;
        tick();
        tick();
        pready = 0;
        #1;
        n_cmp++; if ({b_valid, b_resp, b_id} !== {1'b1, 2'b10, 4'h9}) begin n_fail++;
            $display("FAIL we_bresp: got v=%b resp=%b id=%h want 1 10 9", b_valid, b_resp, b_id);
        end
        tick();
        #1;
        n_cmp++; if ({b_valid, b_resp, b_id} !== {1'b1, 2'b10, 4'h9}) begin n_fail++;
            $display("FAIL we_bresp_hold: got v=%b resp=%b id=%h want 1 10 9", b_valid, b_resp,
                     b_id); end
        b_ready = 1;
        tick();
        b_ready = 0;
        #1;
        n_cmp++; if (b_valid !== 1'b0) begin n_fail++;
            $display("FAIL we_bdone: got %b want 0", b_valid); end
    endtask

    task automatic test_back_to_back();
        logic exp_w;
        apply_reset();
        aw_addr = 32'h1A10_0200; aw_len = 0; aw_burst = 2'b01; w_data = 32'h5; w_strb = 4'hF;
        ar_addr = 32'h1A10_0300; ar_len = 0; ar_burst = 2'b01;
        aw_valid = 1; w_valid = 1; ar_valid = 1;
        pready = 1; b_ready = 1; r_ready = 1;
        for (int g = 0; g < 3; g++) begin
            exp_w = (g != 1);
            #1;
            n_cmp++; if ({aw_ready, w_ready, ar_ready} !== {exp_w, exp_w, ~exp_w}) begin
                n_fail++; $display("FAIL arb_grant %0d: got %b want %b", g,
                                   {aw_ready, w_ready, ar_ready}, {exp_w, exp_w, ~exp_w}); end
            tick();
            n_cmp++; if (pwrite !== exp_w) begin n_fail++;
                $display("FAIL arb_pwrite %0d: got %b want %b", g, pwrite, exp_w); end
            tick(); tick(); tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_wrap_read();
        int beats;
        int psel_seen;
        logic [1:0] resp_s [2];
        logic       last_s [2];
        beats = 0; psel_seen = 0;
        resp_s[0] = 0; resp_s[1] = 0; last_s[0] = 0; last_s[1] = 0;
        ar_addr = 32'h1A10_0400; ar_len = 1; ar_burst = 2'b10; ar_id = 4'h6;
        ar_valid = 1; r_ready = 1;
        #1;
        tick();
        ar_valid = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (psel) psel_seen++;
            if (r_valid) begin
                if (beats < 2) begin
                    resp_s[beats] = r_resp;
                    last_s[beats] = r_last;
                end
                beats++;
            end
            tick();
        end
        r_ready = 0;
        n_cmp++; if (psel_seen !== 0) begin n_fail++;
            $display("FAIL wrap_psel: got %0d cycles with psel want 0", psel_seen); end
        n_cmp++; if (beats !== 2) begin n_fail++;
            $display("FAIL wrap_beats: got %0d want 2", beats); end
        n_cmp++; if ({resp_s[0], last_s[0], resp_s[1], last_s[1]} !== 6'b10_0_10_1) begin
            n_fail++; $display("FAIL wrap_resp: got %b%b %b%b want 100 101",
                               resp_s[0], last_s[0], resp_s[1], last_s[1]); end
        ar_burst = 2'b01;
    endtask

    task automatic test_reset_abort();
        int seen;
        seen = 0;
        aw_addr = 32'h1A10_0500; aw_len = 3; aw_burst = 2'b01; w_data = 32'h77; w_strb = 4'hF;
        aw_valid = 1; w_valid = 1;
        #1;
        tick();
        aw_valid = 0; w_valid = 0;
        tick();
        #1;
        n_cmp++; if ({psel, penable} !== 2'b11) begin n_fail++;
            $display("FAIL abort_pre_access: got %b want 11", {psel, penable}); end
        #2;
        rst_n = 0;
        #1;
        n_cmp++; if ({psel, penable, pwrite, paddr, pwdata} !== 67'h0) begin n_fail++;
            $display("FAIL abort_async: got %b%b%b %h %h want all 0", psel, penable, pwrite,
                     paddr, pwdata); end
        tick(); tick();
        rst_n = 1;
        b_ready = 0; r_ready = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (b_valid || r_valid || psel || w_ready) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++;
            $display("FAIL abort_after: got %0d active cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_incr_read();
        test_wait_error();
        test_back_to_back();
        test_wrap_read();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
